// File: rtl/flood_open_ctrl.sv
// flood_open_ctrl: breadth-first cell opener for board_cover.
// Opens the requested cell; a zero cell also floods its connected zero region and numbered border.
module flood_open_ctrl #(
  parameter int X_SIZE = 16,
  parameter int Y_SIZE = 16,
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_BITS-1:0]        start_x,
  input  logic [Y_BITS-1:0]        start_y,
  output logic [X_BITS-1:0]        rd_x,
  output logic [Y_BITS-1:0]        rd_y,
  input  logic [4:0]               rd_cell,
  input  logic [1:0]               rd_cover,
  output logic                     open_stb,
  output logic [X_BITS-1:0]        open_x,
  output logic [Y_BITS-1:0]        open_y,
  output logic                     busy,
  output logic                     done,
  output logic                     hit_mine,
  output logic [X_BITS+Y_BITS:0]   opened_cnt
);
  localparam int CELLS = X_SIZE * Y_SIZE;
  localparam int CW    = X_BITS + Y_BITS;
  localparam logic [X_BITS+1:0] X_LIM = (X_BITS+2)'(X_SIZE);
  localparam logic [Y_BITS+1:0] Y_LIM = (Y_BITS+2)'(Y_SIZE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_NBR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [X_BITS-1:0] cur_x_q, cur_x_d, rd_x_q, rd_x_d, open_x_q, open_x_d;
  logic [Y_BITS-1:0] cur_y_q, cur_y_d, rd_y_q, rd_y_d, open_y_q, open_y_d;
  logic              open_stb_q, open_stb_d, hit_mine_q, hit_mine_d;
  logic [CW:0]       cnt_q, cnt_d, count_q, count_d;
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CELLS-1:0]  map_q, map_d;
  logic [CW-1:0]     fifo_mem [2**CW];

  logic              push_en, map_clr;
  logic [X_BITS-1:0] push_x;
  logic [Y_BITS-1:0] push_y;
  logic [CW-1:0]     push_cell, nbr_cell;
  logic [1:0]        dx, dy;
  logic [X_BITS+1:0] nbr_x;
  logic [Y_BITS+1:0] nbr_y;
  logic              nbr_ok;

  // Neighbour offsets as 2-bit two's complement, raster order around the current cell.
  always_comb begin
    dx = 2'b00;
    dy = 2'b00;
    case (idx_q)
      3'd0: begin dx = 2'b11; dy = 2'b11; end
      3'd1: begin dx = 2'b00; dy = 2'b11; end
      3'd2: begin dx = 2'b01; dy = 2'b11; end
      3'd3: begin dx = 2'b11; dy = 2'b00; end
      3'd4: begin dx = 2'b01; dy = 2'b00; end
      3'd5: begin dx = 2'b11; dy = 2'b01; end
      3'd6: begin dx = 2'b00; dy = 2'b01; end
      default: begin dx = 2'b01; dy = 2'b01; end
    endcase
    nbr_x    = {2'b00, cur_x_q} + {{X_BITS{dx[1]}}, dx};
    nbr_y    = {2'b00, cur_y_q} + {{Y_BITS{dy[1]}}, dy};
    nbr_ok   = !nbr_x[X_BITS+1] && (nbr_x < X_LIM) && !nbr_y[Y_BITS+1] && (nbr_y < Y_LIM);
    nbr_cell = CW'(int'(nbr_y[Y_BITS-1:0]) * X_SIZE + int'(nbr_x[X_BITS-1:0]));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    open_stb_d = 1'b0;
    open_x_d   = open_x_q;
    open_y_d   = open_y_q;
    hit_mine_d = hit_mine_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_en    = 1'b0;
    push_x     = start_x;
    push_y     = start_y;
    map_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          map_clr    = 1'b1;
          cnt_d      = '0;
          hit_mine_d = 1'b0;
          push_en    = 1'b1;
          state_d    = S_POP;
        end
      end
      S_POP: begin
        if (count_q == '0) begin
          state_d = S_DONE;
        end else begin
          {cur_y_d, cur_x_d} = fifo_mem[rd_ptr_q];
          rd_x_d   = fifo_mem[rd_ptr_q][X_BITS-1:0];
          rd_y_d   = fifo_mem[rd_ptr_q][CW-1:X_BITS];
          rd_ptr_d = rd_ptr_q + CW'(1);
          count_d  = count_q - (CW+1)'(1);
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (rd_cover != 2'b00) begin
          // Skipped cell with nothing left queued finishes without the extra empty POP cycle.
          state_d = (count_q == '0) ? S_DONE : S_POP;
        end else begin
          open_stb_d = 1'b1;
          open_x_d   = cur_x_q;
          open_y_d   = cur_y_q;
          cnt_d      = cnt_q + (CW+1)'(1);
          if (rd_cell == 5'b11111) begin
            hit_mine_d = 1'b1;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            state_d    = S_DONE;
          end else if (rd_cell == 5'd0) begin
            idx_d   = 3'd0;
            state_d = S_NBR;
          end else begin
            state_d = S_POP;
          end
        end
      end
      S_NBR: begin
        if (nbr_ok && !map_q[nbr_cell]) begin
          push_en = 1'b1;
          push_x  = nbr_x[X_BITS-1:0];
          push_y  = nbr_y[Y_BITS-1:0];
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_POP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
      count_d  = count_q + (CW+1)'(1);
    end
  end

  assign push_cell = CW'(int'(push_y) * X_SIZE + int'(push_x));

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_map
    assign map_d[gi] = (map_q[gi] & ~map_clr) | (push_en & (push_cell == CW'(gi)));
  end

  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr_q] <= {push_y, push_x};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      open_stb_q <= 1'b0;
      open_x_q   <= '0;
      open_y_q   <= '0;
      hit_mine_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      map_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      open_stb_q <= open_stb_d;
      open_x_q   <= open_x_d;
      open_y_q   <= open_y_d;
      hit_mine_q <= hit_mine_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      map_q      <= map_d;
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign open_stb   = open_stb_q;
  assign open_x     = open_x_q;
  assign open_y     = open_y_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign hit_mine   = hit_mine_q;
  assign opened_cnt = cnt_q;
endmodule
